// File: rtl/ram_access_sequencer.sv
// Single-port SRAM access sequencer: FREE -> ADDR -> BUSY -> DATA handshake.
// Optional RAM_MISALIGN_CHECK_EN: misaligned accesses fault instead of force-aligning.
module ram_access_sequencer #(
    parameter int unsigned LATENCY     = 1,
    parameter int unsigned SRAM_ADDR_W = 14
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic [31:0]            ram_addr,
    input  logic [31:0]            ram_store,
    input  logic                   ram_ren,
    input  logic                   ram_wen,
    input  logic [1:0]             ram_width,
    output logic [31:0]            ram_load,
    output logic [1:0]             ram_state,
    output logic                   ram_fault,
    output logic                   sram_en,
    output logic                   sram_we,
    output logic [SRAM_ADDR_W-1:0] sram_addr,
    output logic [3:0]             sram_wbe,
    output logic [31:0]            sram_wdata,
    input  logic [31:0]            sram_rdata
);

    localparam logic [3:0] LAT = 4'(LATENCY);

    typedef enum logic [1:0] {
        RAM_FREE = 2'd0,
        RAM_ADDR = 2'd1,
        RAM_BUSY = 2'd2,
        RAM_DATA = 2'd3
    } state_t;

    state_t      state;
    logic [3:0]  cnt;
    logic        op_wr;
    logic [1:0]  lane;
    logic [1:0]  width_q;
    logic [31:0] load_q;
    logic        fault_q;
    logic        sram_ok;
    logic        unused;

    logic        is_byte;
    logic        is_half;
    logic        misaligned;
    logic [1:0]  lane_n;
    logic [3:0]  wbe_n;
    logic [31:0] wdata_n;

    always_comb begin
        is_byte    = ram_width == 2'd0;
        is_half    = ram_width == 2'd1;
        misaligned = (is_half && ram_addr[0]) ||
                     (!is_byte && !is_half && ram_addr[1:0] != 2'b00);
        lane_n     = 2'b00;
        wbe_n      = 4'b1111;
        wdata_n    = ram_store;
        if (is_byte) begin
            lane_n  = ram_addr[1:0];
            wbe_n   = 4'b0001 << ram_addr[1:0];
            wdata_n = {4{ram_store[7:0]}};
        end else if (is_half) begin
            lane_n  = {ram_addr[1], 1'b0};
            wbe_n   = 4'b0011 << {ram_addr[1], 1'b0};
            wdata_n = {2{ram_store[15:0]}};
        end
    end

    // On the first BUSY cycle the SRAM output is live; afterwards use load_q.
    logic [31:0] cap;
    logic [31:0] shifted;
    logic [31:0] fmt;

    always_comb begin
        cap     = (cnt == LAT) ? sram_rdata : load_q;
        shifted = cap >> {lane, 3'b000};
        unique case (width_q)
            2'd0:    fmt = {24'd0, shifted[7:0]};
            2'd1:    fmt = {16'd0, shifted[15:0]};
            default: fmt = shifted;
        endcase
    end

`ifdef RAM_MISALIGN_CHECK_EN
    assign sram_ok = !misaligned;
    assign unused  = ^ram_addr[31:SRAM_ADDR_W+2];

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            fault_q   <= 1'b0;
            ram_fault <= 1'b0;
        end else begin
            if (state == RAM_FREE && (ram_wen || ram_ren))
                fault_q <= misaligned;
            ram_fault <= (state == RAM_BUSY && cnt == 4'd1) ? fault_q : 1'b0;
        end
    end
`else
    assign sram_ok   = 1'b1;
    assign fault_q   = 1'b0;
    assign ram_fault = 1'b0;
    assign unused    = ^{ram_addr[31:SRAM_ADDR_W+2], misaligned};
`endif

    assign ram_state = state;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state      <= RAM_FREE;
            cnt        <= 4'd0;
            op_wr      <= 1'b0;
            lane       <= 2'b00;
            width_q    <= 2'b00;
            load_q     <= 32'd0;
            ram_load   <= 32'd0;
            sram_en    <= 1'b0;
            sram_we    <= 1'b0;
            sram_addr  <= '0;
            sram_wbe   <= 4'b0000;
            sram_wdata <= 32'd0;
        end else begin
            sram_en  <= 1'b0;
            sram_we  <= 1'b0;
            sram_wbe <= 4'b0000;
            unique case (state)
                RAM_FREE: begin
                    if (ram_wen || ram_ren) begin
                        op_wr      <= ram_wen;
                        lane       <= lane_n;
                        width_q    <= ram_width;
                        sram_en    <= sram_ok;
                        sram_we    <= ram_wen && sram_ok;
                        sram_wbe   <= (ram_wen && sram_ok) ? wbe_n : 4'b0000;
                        sram_wdata <= wdata_n;
                        sram_addr  <= ram_addr[SRAM_ADDR_W+1:2];
                        state      <= RAM_ADDR;
                    end
                end
                RAM_ADDR: begin
                    cnt   <= LAT;
                    state <= RAM_BUSY;
                end
                RAM_BUSY: begin
                    if (cnt == LAT && !op_wr)
                        load_q <= sram_rdata;
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        ram_load <= (op_wr || fault_q) ? 32'd0 : fmt;
                        state    <= RAM_DATA;
                    end
                end
                RAM_DATA: begin
                    ram_load <= 32'd0;
                    state    <= RAM_FREE;
                end
            endcase
        end
    end

endmodule
